// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron stimulus driver: FSM states,
// neuron mode-pin encodings and the chunk-count helper.
package lif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    RUN,
    DONE
  } state_t;

  // nrn_uio encodings: bit0 selects the weight register, bit1 selects run mode
  localparam logic [1:0] UIO_LOAD_I = 2'b00;
  localparam logic [1:0] UIO_LOAD_W = 2'b01;
  localparam logic [1:0] UIO_RUN    = 2'b10;

  // Number of 8-bit bus transfers needed to load one INPUTS-wide vector
  function automatic int calc_nch(input int inputs);
    return (inputs < 8) ? 1 : inputs / 8;
  endfunction

endpackage

// File: rtl/lif_chunk_mux.sv
// Picks byte k of a vector for the neuron data bus. Byte 0 is the most
// significant byte because the neuron shifts its register left by 8 on
// every load. Vectors narrower than 8 bits are zero-padded on the left.
module lif_chunk_mux
  import lif_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter int K_W    = 1
) (
  input  logic [INPUTS-1:0] vec,
  input  logic [K_W-1:0]    k,
  output logic [7:0]        chunk
);

  localparam int NCH = calc_nch(INPUTS);

  logic [NCH*8-1:0] padded;

  // zero-pad the vector to whole bytes and select byte k counting from the top
  always_comb begin
    padded             = '0;
    padded[INPUTS-1:0] = vec;
    chunk              = '0;
    for (int i = 0; i < NCH; i++) begin
      if (k == K_W'(i)) chunk = padded[(NCH-1-i)*8 +: 8];
    end
  end

endmodule

// File: rtl/lif_stimulus_driver.sv
// Host-side transmitter for the LIF neuron load/run pin protocol.
// Takes one command (weights, inputs, run length), loads the neuron
// MSB byte first, runs it for the requested cycles, counts spikes with
// saturation and hands the count back over a valid/ready handshake.
// Optional feature: define LIF_DRV_SPIKE_TRACE_EN to add res_trace[7:0],
// a shift register of the last eight RUN spike samples (LSB newest).
module lif_stimulus_driver
  import lif_pkg::*;
#(
  parameter int N_STAGES = 2,
  parameter int RUN_W    = 8,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2**N_STAGES-1:0] cmd_weights,
  input  logic [2**N_STAGES-1:0] cmd_inputs,
  input  logic [RUN_W-1:0]       cmd_cycles,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CNT_W-1:0]       res_count,
  output logic [7:0]             nrn_ui,
  output logic [1:0]             nrn_uio,
  input  logic                   nrn_spike
`ifdef LIF_DRV_SPIKE_TRACE_EN
  ,
  output logic [7:0]             res_trace
`endif
);

  localparam int INPUTS = 2**N_STAGES;
  localparam int NCH    = calc_nch(INPUTS);
  localparam int K_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCH - 1);

  state_t            state, state_nxt;
  logic [INPUTS-1:0] w_q, i_q;
  logic [RUN_W-1:0]  rem_q;
  logic [K_W-1:0]    k_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic [INPUTS-1:0] mux_vec;
  logic [7:0]        mux_chunk;

  assign accept    = cmd_valid && (state == IDLE);
  assign mux_vec   = (state == LOAD_W) ? w_q : i_q;
  assign res_count = cnt_q;

  lif_chunk_mux #(
    .INPUTS (INPUTS),
    .K_W    (K_W)
  ) u_chunk_mux (
    .vec   (mux_vec),
    .k     (k_q),
    .chunk (mux_chunk)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic and outputs decoded from the registered state
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    nrn_uio   = UIO_LOAD_I;
    nrn_ui    = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        nrn_uio = UIO_LOAD_W;
        nrn_ui  = mux_chunk;
        if (k_q == K_LAST) state_nxt = LOAD_I;
      end
      LOAD_I: begin
        nrn_ui = mux_chunk;
        if (k_q == K_LAST) state_nxt = (rem_q == '0) ? DONE : RUN;
      end
      RUN: begin
        nrn_uio = UIO_RUN;
        if (rem_q == RUN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command latch, chunk index, run countdown and saturating spike counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      i_q   <= '0;
      rem_q <= '0;
      k_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      w_q   <= cmd_weights;
      i_q   <= cmd_inputs;
      rem_q <= cmd_cycles;
      k_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        LOAD_W, LOAD_I: k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        RUN: begin
          rem_q <= rem_q - 1'b1;
          if (nrn_spike && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LIF_DRV_SPIKE_TRACE_EN
  logic [7:0] trace_q;

  // spike history of the current run, newest sample in the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            trace_q <= '0;
    else if (accept)       trace_q <= '0;
    else if (state == RUN) trace_q <= {trace_q[6:0], nrn_spike};
  end

  assign res_trace = trace_q;
`endif

endmodule

// File: tb/tb_lif_stimulus_driver.sv
// Bench for lif_stimulus_driver: a 4-input/4-bit-counter instance for the
// protocol, saturation, backpressure, random and reset scenarios, and a
// 16-input instance for the two-byte load order.
module tb_lif_stimulus_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // instance A: N_STAGES=2 (NCH=1), CNT_W=4
  logic       a_cmd_valid, a_cmd_ready, a_res_valid, a_res_ready, a_nrn_spike;
  logic [3:0] a_cmd_weights, a_cmd_inputs, a_res_count;
  logic [7:0] a_cmd_cycles, a_nrn_ui;
  logic [1:0] a_nrn_uio;

  // instance B: N_STAGES=4 (NCH=2), CNT_W=8
  logic        b_cmd_valid, b_cmd_ready, b_res_valid, b_res_ready, b_nrn_spike;
  logic [15:0] b_cmd_weights, b_cmd_inputs;
  logic [7:0]  b_cmd_cycles, b_res_count, b_nrn_ui;
  logic [1:0]  b_nrn_uio;

`ifdef LIF_DRV_SPIKE_TRACE_EN
  logic [7:0] a_res_trace, b_res_trace;
`endif

  int n_pass  = 0;
  int n_total = 0;

  lif_stimulus_driver #(.N_STAGES(2), .RUN_W(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_weights(a_cmd_weights), .cmd_inputs(a_cmd_inputs), .cmd_cycles(a_cmd_cycles),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_count(a_res_count),
    .nrn_ui(a_nrn_ui), .nrn_uio(a_nrn_uio), .nrn_spike(a_nrn_spike)
`ifdef LIF_DRV_SPIKE_TRACE_EN
    , .res_trace(a_res_trace)
`endif
  );

  lif_stimulus_driver #(.N_STAGES(4), .RUN_W(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_weights(b_cmd_weights), .cmd_inputs(b_cmd_inputs), .cmd_cycles(b_cmd_cycles),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_count(b_res_count),
    .nrn_ui(b_nrn_ui), .nrn_uio(b_nrn_uio), .nrn_spike(b_nrn_spike)
`ifdef LIF_DRV_SPIKE_TRACE_EN
    , .res_trace(b_res_trace)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance A, checked cycle by cycle against the
  // timeline: cycle 1 weights, cycle 2 inputs, cycles 3..c+2 run, then done.
  task automatic run_a(input logic [3:0] w, input logic [3:0] iv, input logic [7:0] c,
                       input bit spk_tied, input int hold, input string nm);
    int         exp_cnt;
    logic       s;
    logic [7:0] exp_trace;
    exp_cnt   = 0;
    exp_trace = 8'h00;
    chk({nm, "_idle_ready"}, a_cmd_ready, 1);
    a_cmd_weights = w;
    a_cmd_inputs  = iv;
    a_cmd_cycles  = c;
    a_cmd_valid   = 1'b1;
    a_res_ready   = (hold == 0);
    step();
    a_cmd_valid   = 1'b0;
    a_cmd_weights = 4'($urandom);
    a_cmd_inputs  = 4'($urandom);
    a_cmd_cycles  = 8'($urandom);
    for (int t = 1; t <= 2 + int'(c); t++) begin
      if (t == 1) begin
        chk({nm, "_uio_w"}, a_nrn_uio, 2'b01);
        chk({nm, "_ui_w"}, a_nrn_ui, {4'b0, w});
      end else if (t == 2) begin
        chk({nm, "_uio_i"}, a_nrn_uio, 2'b00);
        chk({nm, "_ui_i"}, a_nrn_ui, {4'b0, iv});
      end else begin
        chk({nm, "_uio_run"}, a_nrn_uio, 2'b10);
        chk({nm, "_ui_run"}, a_nrn_ui, 0);
      end
      chk({nm, "_busy_rdy_vld"}, {a_cmd_ready, a_res_valid}, 2'b00);
      s = spk_tied ? 1'b1 : 1'($urandom_range(0, 1));
      a_nrn_spike = s;
      if (t > 2) begin
        if (s) exp_cnt++;
        exp_trace = {exp_trace[6:0], s};
      end
      step();
    end
    if (exp_cnt > 15) exp_cnt = 15;
    a_nrn_spike = 1'b1;
    chk({nm, "_done_valid"}, a_res_valid, 1);
    chk({nm, "_done_count"}, a_res_count, exp_cnt);
    chk({nm, "_done_uio"}, a_nrn_uio, 2'b00);
    chk({nm, "_done_ready"}, a_cmd_ready, 0);
`ifdef LIF_DRV_SPIKE_TRACE_EN
    chk({nm, "_trace"}, a_res_trace, exp_trace);
`endif
    for (int h = 0; h < hold; h++) begin
      a_cmd_valid = (h == hold / 2);
      step();
      chk({nm, "_hold_valid"}, a_res_valid, 1);
      chk({nm, "_hold_count"}, a_res_count, exp_cnt);
      chk({nm, "_hold_ready"}, a_cmd_ready, 0);
    end
    a_cmd_valid = 1'b0;
    a_res_ready = 1'b1;
    step();
    chk({nm, "_back_idle"}, {a_cmd_ready, a_res_valid}, 2'b10);
    chk({nm, "_back_uio"}, a_nrn_uio, 2'b00);
  endtask

  initial begin
    logic [7:0] b_ui_exp [7];
    logic [1:0] b_uio_exp[7];
    b_ui_exp  = '{8'hA5, 8'h5A, 8'h3C, 8'h96, 8'h00, 8'h00, 8'h00};
    b_uio_exp = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};

    rst_n = 1'b0;
    a_cmd_valid = 0; a_cmd_weights = 0; a_cmd_inputs = 0; a_cmd_cycles = 0;
    a_res_ready = 0; a_nrn_spike = 0;
    b_cmd_valid = 0; b_cmd_weights = 0; b_cmd_inputs = 0; b_cmd_cycles = 0;
    b_res_ready = 0; b_nrn_spike = 0;

    // reset state
    repeat (2) step();
    chk("rst_ready", a_cmd_ready, 1);
    chk("rst_valid", a_res_valid, 0);
    chk("rst_count", a_res_count, 0);
    chk("rst_ui", a_nrn_ui, 0);
    chk("rst_uio", a_nrn_uio, 0);
    rst_n = 1'b1;
    step();

    run_a(4'hF, 4'hA, 8'd5,  1'b1, 0,  "basic");
    run_a(4'h3, 4'h5, 8'd0,  1'b0, 0,  "zero");
    run_a(4'h9, 4'h6, 8'd20, 1'b1, 0,  "sat");
    run_a(4'hC, 4'h1, 8'd4,  1'b0, 10, "bp");
    for (int r = 0; r < 8; r++)
      run_a(4'($urandom), 4'($urandom), 8'($urandom_range(0, 24)), 1'b0,
            int'($urandom_range(0, 3)), "rnd");

    // asynchronous reset in the middle of RUN
    a_cmd_weights = 4'h7; a_cmd_inputs = 4'hE; a_cmd_cycles = 8'd40;
    a_cmd_valid = 1'b1; a_res_ready = 1'b1; a_nrn_spike = 1'b1;
    step();
    a_cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_uio", a_nrn_uio, 2'b10);
    chk("mid_count", a_res_count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_uio", a_nrn_uio, 0);
    chk("arst_count", a_res_count, 0);
    chk("arst_rdy_vld", {a_cmd_ready, a_res_valid}, 2'b10);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_release_ready", a_cmd_ready, 1);
    run_a(4'hB, 4'h2, 8'd3, 1'b0, 1, "reload");

    // two-byte load order on the wide instance, spike pattern 1,0,1
    b_cmd_weights = 16'hA55A; b_cmd_inputs = 16'h3C96; b_cmd_cycles = 8'd3;
    b_cmd_valid = 1'b1; b_res_ready = 1'b1;
    step();
    b_cmd_valid = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      chk("wide_uio", b_nrn_uio, b_uio_exp[t-1]);
      chk("wide_ui", b_nrn_ui, b_ui_exp[t-1]);
      b_nrn_spike = (t == 5) || (t == 7);
      step();
    end
    b_nrn_spike = 1'b0;
    chk("wide_valid", b_res_valid, 1);
    chk("wide_count", b_res_count, 2);
`ifdef LIF_DRV_SPIKE_TRACE_EN
    chk("wide_trace", b_res_trace, 8'b0000_0101);
`endif
    step();
    chk("wide_back_idle", {b_cmd_ready, b_res_valid}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lif_stimulus_driver.md
# lif_stimulus_driver

Host-side driver for the LIF neuron tile's pin protocol; it is the transmitter for the neuron's load/run interface. It accepts one command per transaction over a valid/ready handshake, carrying a weight vector, an input vector and a run length. It shifts the weights and inputs into the neuron over the 8-bit data bus, switches the neuron to integrate mode for the requested cycles, counts spikes, and returns the count over a second valid/ready handshake. It sits between a test controller or an upstream layer and one neuron instance.

## Interface
- N_STAGES, 2, neuron adder depth; INPUTS = 2**N_STAGES, the width of the weight and input vectors.
- RUN_W, 8, width of the run-length field.
- CNT_W, 8, width of the spike counter.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_weights  in  INPUTS  weight bits, +1/-1 per bit as the neuron encodes them.
- cmd_inputs  in  INPUTS  input spike vector.
- cmd_cycles  in  RUN_W  number of integrate cycles.
- res_valid  out  1  result held until accepted.
- res_ready  in  1  result consumer ready.
- res_count  out  CNT_W  spikes counted in the run.
- nrn_ui  out  8  neuron data bus.
- nrn_uio  out  2  bit0 = 1 selects weights, 0 selects inputs; bit1 = 0 load mode, 1 run mode.
- nrn_spike  in  1  neuron spike output, combinational on the neuron side.

## Operation
- NCH = max(1, INPUTS/8) chunks per vector. Chunks go most-significant byte first, because the neuron shifts left by 8 per load. When INPUTS < 8, the upper bits of nrn_ui are 0.
- FSM states: IDLE → LOAD_W → LOAD_I → RUN → DONE → IDLE.
- **IDLE:** cmd_ready=1, nrn_uio=2'b00, nrn_ui=0. This loads zero inputs only and leaves weights and membrane untouched.
- **Accept:** on cmd_valid&&cmd_ready, latch cmd_* and clear the counter.
- **LOAD_W:** runs for NCH cycles with nrn_uio=2'b01 and nrn_ui = chunk k of the weights.
- **LOAD_I:** runs for NCH cycles with nrn_uio=2'b00 and nrn_ui = chunk k of the inputs.
- **RUN:** nrn_uio=2'b10, nrn_ui=0. Lasts cmd_cycles cycles. nrn_spike is sampled at each rising edge while in RUN; each sample of 1 increments the counter.
- If cmd_cycles=0, RUN is skipped: LOAD_I goes straight to DONE and res_count=0.
- The counter saturates at 2**CNT_W-1 and does not wrap.
- **DONE:** res_valid=1; res_count stays stable. On res_valid&&res_ready, return to IDLE.
- cmd_valid is ignored outside IDLE. Commands are not queued.

## Timing
- Reset values (asynchronous): state=IDLE, cmd_ready=1, res_valid=0, res_count=0, nrn_ui=0, nrn_uio=2'b00, all latched fields 0.
- All outputs are registered or decoded from state registers only. There is no combinational path from nrn_spike or res_ready to any output.
- Accept edge is t0. LOAD_W occupies cycles 1..NCH. LOAD_I occupies NCH+1..2NCH. RUN occupies the next cmd_cycles cycles.
- res_valid first rises in cycle 2·NCH + cmd_cycles + 1.
- cmd_ready rises in the cycle after the res handshake edge. Back-to-back throughput is one command per 2·NCH + cmd_cycles + 2 cycles minimum.
- A res_ready that is already high when res_valid rises completes the handshake at the first DONE edge.
- Reset asserted mid-operation aborts immediately to the reset values. The neuron is left partially loaded; the next command fully reloads it.

## Configuration
- LIF_DRV_SPIKE_TRACE_EN defined:
  - Adds output res_trace[7:0], a shift register of RUN samples with the LSB as the most recent sample.
  - The trace is cleared on accept and held through DONE.
  - When cmd_cycles < 8, the upper bits stay 0.
- LIF_DRV_SPIKE_TRACE_EN undefined: the port and register are absent. Behaviour is otherwise identical.

## Structure
- Package lif_pkg holds:
  - the state enum (IDLE, LOAD_W, LOAD_I, RUN, DONE);
  - the nrn_uio encodings (UIO_LOAD_I=2'b00, UIO_LOAD_W=2'b01, UIO_RUN=2'b10);
  - the NCH calculation function.
- One sub-module, lif_chunk_mux, selects chunk k (MSB-first, zero-padded) from an INPUTS-wide vector. It is instantiated once and driven by the current state's vector.

## Test plan
All scenarios use N_STAGES=2 (NCH=1) unless noted.
1. **Reset:** rst_n low mid-RUN → outputs at reset values within the same cycle, with no clock edge needed. After release, cmd_ready=1.
2. **Basic:** weights=4'hF, inputs=4'hA, cycles=5, nrn_spike tied 1 → nrn_ui=0x0F with uio=01 in cycle 1, nrn_ui=0x0A with uio=00 in cycle 2, uio=10 in cycles 3–7, res_valid in cycle 8 with res_count=5.
3. **Zero run:** cycles=0 → uio never 10, res_valid in cycle 3, res_count=0.
4. **Saturation:** CNT_W=4, cycles=20, spike=1 → res_count=15.
5. **Backpressure:** res_ready held low for 10 cycles → res_valid and res_count stable, cmd_ready=0, and a cmd_valid pulse is ignored.
6. **Wide variant:** N_STAGES=4 (NCH=2), weights=16'hA55A → nrn_ui=0xA5 then 0x5A with uio=01. With LIF_DRV_SPIKE_TRACE_EN, spike pattern 1,0,1 → res_trace=8'b0000_0101.
